data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states between request acceptance and response (range 0..15).
REQ-003 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_read  input  1  read request.
REQ-006 SHALL have port mem_write  input  1  write request.
REQ-007 SHALL have port addr  input  32  byte address (the ALU result).
REQ-008 SHALL have port write_data  input  32  store data, already lane-aligned.
REQ-009 SHALL have port byte_en  input  4  write byte strobes; bit i selects write_data[8i+7:8i].
REQ-010 SHALL have port read_data  output  32  full word read; valid only while ready=1.
REQ-011 SHALL have port ready  output  1  one-cycle response strobe.
REQ-012 SHALL have port error  output  1  response is an error; qualified by ready.

Function
REQ-013 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-014 SHALL accept a request in IDLE when mem_read|mem_write=1 and capture addr, write_data, byte_en and request type on that edge.
REQ-015 SHALL ignore every input change while in WAIT or RESP.
REQ-016 SHALL count WAIT_CYCLES cycles in WAIT, then enter RESP; WAIT_CYCLES=0 SHALL skip WAIT, giving ready the cycle after acceptance.
REQ-017 SHALL assert ready for exactly one cycle in RESP, then return to IDLE; a new request SHALL be acceptable the cycle after ready.
REQ-018 SHALL use word index addr[ADDR_LSB+log2(DEPTH_WORDS)-1:ADDR_LSB]; when addr>=DEPTH_WORDS*4, SHALL respond error=1, read_data=0, with no write.
REQ-019 SHALL, on a write, update only the byte_en lanes, committing on the RESP cycle; byte_en=0000 SHALL complete with no change and error=0.
REQ-020 SHALL present the captured word on read_data in RESP for a read and drive read_data=0 for a write or error.
REQ-021 SHALL treat mem_read=1 and mem_write=1 together as an error response with no write.
REQ-022 SHALL hold ready=0, error=0 and read_data=0 outside RESP.

Reset
REQ-023 SHALL, with reset=1 at an edge, enter IDLE and drive ready=0, error=0 and read_data=0 on the following cycle.
REQ-024 SHALL abandon an in-flight request on reset, with no write committed and no ready issued.
REQ-025 SHALL leave storage contents unaffected by reset.

Configuration
REQ-026 SHALL, with DMEM_ALIGN_CHECK_EN defined, respond error=1 with no write when the access is misaligned: a 4-lane byte_en with addr[1:0]!=0, a 2-lane byte_en with addr[0]=1, or a read with addr[1:0]!=0.
REQ-027 SHALL, without DMEM_ALIGN_CHECK_EN, ignore addr[1:0] and never flag misalignment.

Structure
REQ-028 SHALL take the FSM state enum, WORD_BYTES=4, ADDR_LSB=2 and the wait-counter width from shared package dmem_pkg.
REQ-029 SHALL place storage in one sub-module dmem_array, a synchronous byte-enable RAM with 1-cycle read latency, hidden inside WAIT/RESP timing.

Verification
REQ-030 SHALL verify write then read: write addr=0x10, data=0xDEADBEEF, byte_en=1111; then read 0x10 -> ready exactly 3 cycles after each acceptance (WAIT_CYCLES=2), read_data=0xDEADBEEF, error=0.
REQ-031 SHALL verify byte strobes: preload 0x11223344 at 0x20; write 0x0000AA00 with byte_en=0010; read -> 0x1122AA44.
REQ-032 SHALL verify range and collision errors: read at addr=0x1000 with DEPTH_WORDS=1024 -> error=1, read_data=0; mem_read=mem_write=1 at 0x0 -> error=1 and the word is unchanged.
REQ-033 SHALL verify reset mid-operation: write 0x55555555 to 0x30, assert reset in WAIT -> no ready; then read 0x30 -> the prior value.
REQ-034 SHALL verify alignment: write at addr=0x42 with byte_en=1111 -> error=1 and no write when DMEM_ALIGN_CHECK_EN is defined; without it, the write lands at word 0x40.
REQ-035 SHALL verify zero-wait back-to-back: WAIT_CYCLES=0 with requests held continuously -> ready on every second cycle, with inputs changed during RESP ignored.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared FSM state, word geometry and wait-counter width for the data memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_LSB   = 2;
    localparam int WAIT_CNT_W = 4;

    function automatic logic [2:0] lane_count(input logic [3:0] be);
        lane_count = 3'(be[0]) + 3'(be[1]) + 3'(be[2]) + 3'(be[3]);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write strobes.
// Latency: read data appears one cycle after the read address; writes commit on the edge.
// Backpressure: none, one read and one write per cycle.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic [WORD_BYTES-1:0]          be_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr_i,
    input  logic [31:0]                    wdata_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Storage is deliberately never reset so contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder: IDLE -> WAIT -> RESP, one-cycle ready strobe.
// Latency: ready WAIT_CYCLES+1 cycles after acceptance; optional DMEM_ALIGN_CHECK_EN flags misaligned accesses.
// Backpressure: requests are only accepted in IDLE; inputs are ignored in WAIT and RESP.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_en,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        error
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    dmem_state_e           state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]         idx_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic                  rd_q, err_q;

    logic                  req_vld, accept, req_err, mem_we;
    logic [AW-1:0]         req_idx, raddr;
    logic [31:0]           ram_rdata;

    assign req_vld = mem_read | mem_write;
    assign accept  = (state_q == ST_IDLE) && req_vld;
    assign req_idx = addr[ADDR_LSB +: AW];

    always_comb begin
        req_err = (mem_read && mem_write) || ({1'b0, addr} >= ADDR_LIMIT);
`ifdef DMEM_ALIGN_CHECK_EN
        if (mem_read && (addr[1:0] != 2'b00)) req_err = 1'b1;
        if (mem_write && (byte_en == 4'hF) && (addr[1:0] != 2'b00)) req_err = 1'b1;
        if (mem_write && (lane_count(byte_en) == 3'd2) && addr[0]) req_err = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= req_idx;
            wdata_q <= write_data;
            be_q    <= byte_en;
            rd_q    <= mem_read;
            err_q   <= req_err;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_vld) begin
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready     = 1'b0;
        error     = 1'b0;
        read_data = '0;
        mem_we    = 1'b0;
        if (state_q == ST_RESP) begin
            ready = 1'b1;
            error = err_q;
            if (!err_q) begin
                if (rd_q) read_data = ram_rdata;
                else      mem_we    = 1'b1;
            end
        end
    end

    // Reading the live address in IDLE lets the RAM latency fit even with zero wait states.
    assign raddr = (state_q == ST_IDLE) ? req_idx : idx_q;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .be_i    (be_q),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .raddr_i (raddr),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, reset and zero-wait sequences, randomized model check.
module tb_data_mem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        mem_read, mem_write;
    logic [31:0] addr, write_data, read_data;
    logic [3:0]  byte_en;
    logic        ready, error;

    logic        z_read, z_write;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic [3:0]  z_be;
    logic        z_ready, z_error;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .write_data(write_data), .byte_en(byte_en),
        .read_data(read_data), .ready(ready), .error(error)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .mem_read(z_read), .mem_write(z_write),
        .addr(z_addr), .write_data(z_wdata), .byte_en(z_be),
        .read_data(z_rdata), .ready(z_ready), .error(z_error)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] mdl [0:1023];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.be = be; v.exp_rd = exp_rd; v.exp_err = exp_err;
        tbl.push_back(v);
    endtask

    // Issue one request on the WAIT_CYCLES=2 instance, scribbling on the inputs while it is busy.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] got_rd, output logic got_err,
                          output int lat);
        bit seen;
        bit quiet;
        seen = 1'b0; quiet = 1'b1;
        got_rd = '0; got_err = 1'b0; lat = -1;
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr = a; write_data = d; byte_en = be;
        @(posedge clk);
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (ready) begin
                seen = 1'b1; lat = n; got_rd = read_data; got_err = error;
                mem_read = 1'b0; mem_write = 1'b0;
            end else begin
                if (error !== 1'b0 || read_data !== 32'h0) quiet = 1'b0;
                {mem_read, mem_write} = 2'($urandom_range(0, 3));
                addr = $urandom; write_data = $urandom; byte_en = 4'($urandom);
            end
        end
        chk("response_seen", 32'(seen), 32'd1);
        if (seen) begin
            @(negedge clk);
            chk("ready_one_cycle", 32'(ready), 32'd0);
        end else begin
            mem_read = 1'b0; mem_write = 1'b0;
        end
        chk("quiet_outside_resp", 32'(quiet), 32'd1);
    endtask

    task automatic model(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] erd, output logic eerr);
        int idx;
        int lanes;
        idx   = int'(a[11:2]);
        lanes = int'(be[0]) + int'(be[1]) + int'(be[2]) + int'(be[3]);
        eerr  = (rd && wr) || (a >= 32'h1000);
        if (ALIGN) begin
            if (rd && a[1:0] != 2'b00) eerr = 1'b1;
            if (wr && lanes == 4 && a[1:0] != 2'b00) eerr = 1'b1;
            if (wr && lanes == 2 && a[0]) eerr = 1'b1;
        end
        erd = '0;
        if (!eerr && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
            end
        end
        if (!eerr && rd) erd = mdl[idx];
    endtask

    initial begin
        logic [31:0] grd, erd, ra, rd32;
        logic        gerr, eerr, rr, rw;
        logic [3:0]  rbe;
        int          lat, kind;
        bit          rst_rdy;
        logic [31:0] zv [0:9];

        reset = 1'b1;
        mem_read = 0; mem_write = 0; addr = 0; write_data = 0; byte_en = 0;
        z_read = 0; z_write = 0; z_addr = 0; z_wdata = 0; z_be = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_error", 32'(error), 32'd0);
        chk("reset_rdata", read_data, 32'd0);
        chk("reset_ready_z", 32'(z_ready), 32'd0);

        add(0, 1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0, 0);
        add(1, 0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 0);
        add(0, 1, 32'h20,  32'h11223344, 4'hF, 32'h0, 0);
        add(0, 1, 32'h20,  32'h0000AA00, 4'h2, 32'h0, 0);
        add(1, 0, 32'h20,  32'h0,        4'h0, 32'h1122AA44, 0);
        add(1, 0, 32'h1000, 32'h0,       4'h0, 32'h0, 1);
        add(0, 1, 32'h0,   32'hCAFEF00D, 4'hF, 32'h0, 0);
        add(1, 1, 32'h0,   32'h00000000, 4'hF, 32'h0, 1);
        add(1, 0, 32'h0,   32'h0,        4'h0, 32'hCAFEF00D, 0);
        add(0, 1, 32'h20,  32'hFFFFFFFF, 4'h0, 32'h0, 0);
        add(1, 0, 32'h20,  32'h0,        4'h0, 32'h1122AA44, 0);
        add(0, 1, 32'h30,  32'h12345678, 4'hF, 32'h0, 0);
        add(0, 1, 32'h40,  32'h01010101, 4'hF, 32'h0, 0);
        add(0, 1, 32'h42,  32'hA5A5A5A5, 4'hF, 32'h0, ALIGN);
        add(1, 0, 32'h40,  32'h0,        4'h0, ALIGN ? 32'h01010101 : 32'hA5A5A5A5, 0);
        add(1, 0, 32'h41,  32'h0,        4'h0, ALIGN ? 32'h0 : 32'hA5A5A5A5, ALIGN);
        add(0, 1, 32'hFFC, 32'h89ABCDEF, 4'hF, 32'h0, 0);
        add(1, 0, 32'hFFC, 32'h0,        4'h0, 32'h89ABCDEF, 0);
        add(0, 1, 32'h1000, 32'h13572468, 4'hF, 32'h0, 1);
        add(0, 1, 32'h22,  32'h77660000, 4'hC, 32'h0, 0);
        add(1, 0, 32'h20,  32'h0,        4'h0, 32'h7766AA44, 0);
        add(0, 1, 32'h23,  32'h0000BBCC, 4'h3, 32'h0, ALIGN);
        add(1, 0, 32'h20,  32'h0,        4'h0, ALIGN ? 32'h7766AA44 : 32'h7766BBCC, 0);

        foreach (tbl[i]) begin
            do_req(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].be, grd, gerr, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d_error", i), 32'(gerr), 32'(tbl[i].exp_err));
            chk($sformatf("vec%0d_rdata", i), grd, tbl[i].exp_rd);
        end

        // Reset while a write to 0x30 sits in WAIT: nothing responds and the old word survives.
        @(negedge clk);
        mem_write = 1'b1; addr = 32'h30; write_data = 32'h55555555; byte_en = 4'hF;
        @(posedge clk);
        @(negedge clk);
        mem_write = 1'b0;
        reset = 1'b1;
        rst_rdy = ready;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_error", 32'(error), 32'd0);
        chk("rst_mid_rdata", read_data, 32'd0);
        for (int n = 0; n < 6; n++) begin
            if (ready) rst_rdy = 1'b1;
            @(negedge clk);
        end
        chk("rst_mid_no_ready", 32'(rst_rdy), 32'd0);
        do_req(1, 0, 32'h30, 32'h0, 4'h0, grd, gerr, lat);
        chk("rst_mid_readback", grd, 32'h12345678);
        chk("rst_mid_readback_err", 32'(gerr), 32'd0);

        // Zero-wait instance with requests held every cycle: ready alternates, RESP-cycle inputs dropped.
        for (int k = 0; k < 10; k++) zv[k] = $urandom;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            chk($sformatf("zw_ready_c%0d", c), 32'(z_ready), 32'(c % 2));
            chk($sformatf("zw_rdata_c%0d", c), z_rdata,
                (c % 2 == 1 && c >= 11) ? zv[c - 11] : 32'h0);
            chk($sformatf("zw_error_c%0d", c), 32'(z_error), 32'd0);
            if (c < 10) begin
                z_write = 1'b1; z_read = 1'b0; z_addr = 32'(c * 4); z_wdata = zv[c]; z_be = 4'hF;
            end else if (c < 20) begin
                z_write = 1'b0; z_read = 1'b1; z_addr = 32'((c - 10) * 4); z_wdata = $urandom; z_be = 4'($urandom);
            end else begin
                z_write = 1'b0; z_read = 1'b0;
            end
        end

        // Randomized traffic over a preloaded 16-word window, checked against the model.
        for (int k = 0; k < 16; k++) begin
            rd32 = $urandom;
            ra = 32'h100 + 32'(k * 4);
            model(1'b0, 1'b1, ra, rd32, 4'hF, erd, eerr);
            do_req(1'b0, 1'b1, ra, rd32, 4'hF, grd, gerr, lat);
            chk($sformatf("pre%0d_error", k), 32'(gerr), 32'(eerr));
        end
        for (int t = 0; t < 150; t++) begin
            kind = $urandom_range(0, 9);
            ra = 32'h100 + 32'($urandom_range(0, 15) * 4);
            if (kind < 2) ra = ra + 32'($urandom_range(1, 3));
            if (kind == 9) ra = 32'h1000 | $urandom;
            kind = $urandom_range(0, 9);
            rr = (kind <= 4) || (kind == 9);
            rw = (kind >= 5);
            rbe = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            rd32 = $urandom;
            model(rr, rw, ra, rd32, rbe, erd, eerr);
            do_req(rr, rw, ra, rd32, rbe, grd, gerr, lat);
            chk($sformatf("rnd%0d_latency", t), 32'(lat), 32'd3);
            chk($sformatf("rnd%0d_error", t), 32'(gerr), 32'(eerr));
            chk($sformatf("rnd%0d_rdata", t), grd, erd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
